// File: rtl/fc_mac_accum_2_pkg.sv
// +----------------------------------------------------------------------------+
// | fc_mac_accum_2_pkg : shared sizes, state encoding and drain length for the |
// |                      FC multiply-accumulate block.  Rev 1.0               |
// +----------------------------------------------------------------------------+
`default_nettype none

package fc_mac_accum_2_pkg;

  localparam int DEF_DATA_WIDTH_FC                = 16;
  localparam int DEF_ACCUM_DATA_WIDTH_FC          = 32;
  localparam int DEF_INNEURON                     = 64;
  localparam int DEF_OUTNEURON                    = 10;
  localparam int DEF_PO                           = 1;
  localparam int DEF_FC_INNEURON_ADDR_WIDTH       = 6;
  localparam int DEF_FC_WEIGHT_ADDR_WIDTH         = 10;
  localparam int DEF_FC_COUNT_SLOAD_BITWIDTH      = 3;
  localparam int DEF_FC_COUNT_OUT_NEURON_BITWIDTH = 4;

  localparam int DRAIN_LEN = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MAC   = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } fc_state_e;

endpackage

`default_nettype wire

// File: rtl/fc_mac_accum_2_mac_unit.sv
// +----------------------------------------------------------------------------+
// | fc_mac_unit_2 : signed multiply with load/accumulate; saturating adds when |
// |                 FC_ACCUM_SAT_EN is defined, two's-complement wrap else.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module fc_mac_unit_2
  import fc_mac_accum_2_pkg::*;
#(
  parameter int DATA_WIDTH_FC       = DEF_DATA_WIDTH_FC,
  parameter int ACCUM_DATA_WIDTH_FC = DEF_ACCUM_DATA_WIDTH_FC
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           i_en,
  input  logic                           i_load,
  input  logic [DATA_WIDTH_FC-1:0]       i_a,
  input  logic [DATA_WIDTH_FC-1:0]       i_b,
  output logic [ACCUM_DATA_WIDTH_FC-1:0] o_acc
);

  localparam int c_pw = 2 * DATA_WIDTH_FC;
  localparam int c_aw = ACCUM_DATA_WIDTH_FC;

  logic signed [c_pw-1:0] w_a_ext;
  logic signed [c_pw-1:0] w_b_ext;
  logic signed [c_pw-1:0] w_prod;
  logic signed [c_aw-1:0] w_prod_ext;
  logic signed [c_aw-1:0] w_base;
  logic signed [c_aw-1:0] w_sum;
  logic        [c_aw-1:0] w_acc_nxt;
  logic        [c_aw-1:0] r_acc;

  // Operands are widened first so the product is formed at full width.
  assign w_a_ext    = c_pw'($signed(i_a));
  assign w_b_ext    = c_pw'($signed(i_b));
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_prod_ext = c_aw'(w_prod);
  assign w_base     = i_load ? '0 : $signed(r_acc);
  assign w_sum      = w_base + w_prod_ext;

`ifdef FC_ACCUM_SAT_EN
  logic w_ovf;
  assign w_ovf = (w_base[c_aw-1] == w_prod_ext[c_aw-1]) &&
                 (w_sum[c_aw-1]  != w_base[c_aw-1]);

  always_comb begin
    w_acc_nxt = w_sum;
    if (w_ovf) begin
      w_acc_nxt = w_base[c_aw-1] ? {1'b1, {(c_aw-1){1'b0}}}
                                 : {1'b0, {(c_aw-1){1'b1}}};
    end
  end
`else
  assign w_acc_nxt = w_sum;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_acc_nxt;
    end
  end

  assign o_acc = r_acc;

endmodule

`default_nettype wire

// File: rtl/fc_mac_accum_2.sv
// +----------------------------------------------------------------------------+
// | fc_mac_accum_2 : sequential FC neuron dot-product engine with drain phase  |
// |                  for the result writer. Option macro: FC_ACCUM_SAT_EN.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module fc_mac_accum_2
  import fc_mac_accum_2_pkg::*;
#(
  parameter int DATA_WIDTH_FC                = DEF_DATA_WIDTH_FC,
  parameter int ACCUM_DATA_WIDTH_FC          = DEF_ACCUM_DATA_WIDTH_FC,
  parameter int INNEURON                     = DEF_INNEURON,
  parameter int OUTNEURON                    = DEF_OUTNEURON,
  parameter int PO                           = DEF_PO,
  parameter int FC_INNEURON_ADDR_WIDTH       = DEF_FC_INNEURON_ADDR_WIDTH,
  parameter int FC_WEIGHT_ADDR_WIDTH         = DEF_FC_WEIGHT_ADDR_WIDTH,
  parameter int FC_COUNT_SLOAD_BITWIDTH      = DEF_FC_COUNT_SLOAD_BITWIDTH,
  parameter int FC_COUNT_OUT_NEURON_BITWIDTH = DEF_FC_COUNT_OUT_NEURON_BITWIDTH
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    i_enable,
  input  logic                                    i_start,
  input  logic [DATA_WIDTH_FC-1:0]                i_in_data,
  input  logic [DATA_WIDTH_FC-1:0]                i_w_data,
  output logic [FC_INNEURON_ADDR_WIDTH-1:0]       o_in_addr,
  output logic [FC_WEIGHT_ADDR_WIDTH-1:0]         o_w_addr,
  output logic [ACCUM_DATA_WIDTH_FC-1:0]          o_result,
  output logic [FC_COUNT_SLOAD_BITWIDTH-1:0]      o_count_sload,
  output logic [FC_COUNT_OUT_NEURON_BITWIDTH-1:0] o_count_out,
  output logic                                    o_busy,
  output logic                                    o_done
);

  localparam int c_iaw = FC_INNEURON_ADDR_WIDTH;
  localparam int c_waw = FC_WEIGHT_ADDR_WIDTH;
  localparam int c_sw  = FC_COUNT_SLOAD_BITWIDTH;
  localparam int c_nw  = FC_COUNT_OUT_NEURON_BITWIDTH;

  localparam logic [c_iaw-1:0] c_last_in   = c_iaw'(INNEURON - 1);
  localparam logic [c_nw-1:0]  c_num_neu   = c_nw'(OUTNEURON / PO);
  localparam logic [c_sw-1:0]  c_drain_end = c_sw'(DRAIN_LEN);

  fc_state_e          r_state,       w_state_nxt;
  logic [c_iaw-1:0]   r_in_addr,     w_in_addr_nxt;
  logic [c_waw-1:0]   r_w_addr,      w_w_addr_nxt;
  logic [c_sw-1:0]    r_count_sload, w_count_sload_nxt;
  logic [c_nw-1:0]    r_count_out,   w_count_out_nxt;
  logic               r_done,        w_done_nxt;
  logic               r_pend,        w_pend_nxt;
  logic               r_pend_first,  w_pend_first_nxt;

  logic                     r_stall;
  logic [DATA_WIDTH_FC-1:0] r_cap_in;
  logic [DATA_WIDTH_FC-1:0] r_cap_w;
  logic [DATA_WIDTH_FC-1:0] w_op_in;
  logic [DATA_WIDTH_FC-1:0] w_op_w;
  logic                     w_acc_en;

  // While stalled the RAMs present data for the held address, not the one
  // issued before the stall, so the in-flight operands are captured on the
  // first stalled cycle and replayed on the first cycle after it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall  <= 1'b0;
      r_cap_in <= '0;
      r_cap_w  <= '0;
    end else begin
      r_stall <= ~i_enable;
      if (!i_enable && !r_stall) begin
        r_cap_in <= i_in_data;
        r_cap_w  <= i_w_data;
      end
    end
  end

  assign w_op_in  = r_stall ? r_cap_in : i_in_data;
  assign w_op_w   = r_stall ? r_cap_w  : i_w_data;
  assign w_acc_en = i_enable & r_pend;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_in_addr     <= '0;
      r_w_addr      <= '0;
      r_count_sload <= '0;
      r_count_out   <= '0;
      r_done        <= 1'b0;
      r_pend        <= 1'b0;
      r_pend_first  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_in_addr     <= w_in_addr_nxt;
      r_w_addr      <= w_w_addr_nxt;
      r_count_sload <= w_count_sload_nxt;
      r_count_out   <= w_count_out_nxt;
      r_done        <= w_done_nxt;
      r_pend        <= w_pend_nxt;
      r_pend_first  <= w_pend_first_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_in_addr_nxt     = r_in_addr;
    w_w_addr_nxt      = r_w_addr;
    w_count_sload_nxt = r_count_sload;
    w_count_out_nxt   = r_count_out;
    w_done_nxt        = r_done;
    w_pend_nxt        = r_pend;
    w_pend_first_nxt  = r_pend_first;

    if (i_enable) begin
      w_done_nxt       = 1'b0;
      w_pend_nxt       = (r_state == ST_MAC);
      w_pend_first_nxt = (r_state == ST_MAC) && (r_in_addr == '0);

      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            w_state_nxt       = ST_MAC;
            w_in_addr_nxt     = '0;
            w_count_sload_nxt = '0;
            w_count_out_nxt   = r_count_out + c_nw'(1);
          end
        end
        ST_MAC: begin
          w_w_addr_nxt = r_w_addr + c_waw'(1);
          if (r_in_addr == c_last_in) begin
            w_in_addr_nxt = '0;
            w_state_nxt   = ST_FLUSH;
          end else begin
            w_in_addr_nxt = r_in_addr + c_iaw'(1);
          end
        end
        ST_FLUSH: begin
          w_state_nxt       = ST_DRAIN;
          w_count_sload_nxt = c_sw'(1);
        end
        ST_DRAIN: begin
          if (r_count_sload == c_drain_end) begin
            w_count_sload_nxt = '0;
            if (r_count_out < c_num_neu) begin
              w_state_nxt     = ST_MAC;
              w_count_out_nxt = r_count_out + c_nw'(1);
            end else begin
              w_state_nxt = ST_DONE;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_count_sload_nxt = r_count_sload + c_sw'(1);
          end
        end
        ST_DONE: begin
          w_state_nxt     = ST_IDLE;
          w_count_out_nxt = '0;
          w_w_addr_nxt    = '0;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  fc_mac_unit_2 #(
    .DATA_WIDTH_FC       (DATA_WIDTH_FC),
    .ACCUM_DATA_WIDTH_FC (ACCUM_DATA_WIDTH_FC)
  ) u_mac (
    .clock  (clock),
    .reset  (reset),
    .i_en   (w_acc_en),
    .i_load (r_pend_first),
    .i_a    (w_op_in),
    .i_b    (w_op_w),
    .o_acc  (o_result)
  );

  assign o_in_addr     = r_in_addr;
  assign o_w_addr      = r_w_addr;
  assign o_count_sload = r_count_sload;
  assign o_count_out   = r_count_out;
  assign o_done        = r_done;
  assign o_busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_fc_mac_accum_2.sv
// +----------------------------------------------------------------------------+
// | tb_fc_mac_accum_2 : directed vector bench for fc_mac_accum_2 with a small  |
// |                     (4-input, 2-neuron) configuration. Rev 1.0             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fc_mac_accum_2;

  logic        clock;
  logic        reset;
  logic        i_enable;
  logic        i_start;
  logic [15:0] i_in_data;
  logic [15:0] i_w_data;
  logic [1:0]  o_in_addr;
  logic [9:0]  o_w_addr;
  logic [31:0] o_result;
  logic [2:0]  o_count_sload;
  logic [3:0]  o_count_out;
  logic        o_busy;
  logic        o_done;

  logic [15:0] in_mem [0:3];
  logic [15:0] w_mem  [0:1023];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0][15:0] in_v;
    logic [3:0][15:0] w0;
    logic [3:0][15:0] w1;
    logic [31:0]      r0;
    logic [31:0]      r1;
  } vec_t;

  vec_t vecs [6];

  fc_mac_accum_2 #(
    .INNEURON               (4),
    .OUTNEURON              (2),
    .PO                     (1),
    .FC_INNEURON_ADDR_WIDTH (2),
    .FC_WEIGHT_ADDR_WIDTH   (10)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .i_enable      (i_enable),
    .i_start       (i_start),
    .i_in_data     (i_in_data),
    .i_w_data      (i_w_data),
    .o_in_addr     (o_in_addr),
    .o_w_addr      (o_w_addr),
    .o_result      (o_result),
    .o_count_sload (o_count_sload),
    .o_count_out   (o_count_out),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read RAM models, reading every cycle regardless of enable.
  always @(posedge clock) begin
    i_in_data <= in_mem[o_in_addr];
    i_w_data  <= w_mem[o_w_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic load_vec(input int v);
    for (int i = 0; i < 4; i++) begin
      in_mem[i]    = vecs[v].in_v[i];
      w_mem[i]     = vecs[v].w0[i];
      w_mem[4 + i] = vecs[v].w1[i];
    end
  endtask

  // One full start-to-done run; stall_pct gives the chance of enable=0 per
  // cycle, poke raises start once in the middle of the first drain.
  task automatic run_vec(input int v, input int stall_pct, input bit poke);
    logic [7:0] seq [$];
    logic [7:0] exp_e;
    int  cyc;
    int  n_done;
    bit  prev_done;
    bit  poked;
    bit  first;
    bit  en;
    load_vec(v);
    @(negedge clock);
    i_enable = 1'b1;
    i_start  = 1'b1;
    cyc = 0; n_done = 0; prev_done = 1'b0; poked = 1'b0; first = 1'b1;
    forever begin
      @(negedge clock);
      i_start = 1'b0;
      cyc++;
      if (first) begin
        check($sformatf("v%0d_first_mac", v),
              {o_in_addr, o_w_addr, o_count_out, o_count_sload, o_busy},
              {2'd0, 10'd0, 4'd1, 3'd0, 1'b1});
        first = 1'b0;
      end
      if (o_done && !prev_done) n_done++;
      prev_done = o_done;
      if (o_count_sload != 3'd0) begin
        check($sformatf("v%0d_n%0d_result", v, o_count_out), o_result,
              (o_count_out == 4'd1) ? vecs[v].r0 : vecs[v].r1);
      end
      if (n_done > 0 && !o_done && !o_busy) break;
      if (cyc > 400) begin
        check($sformatf("v%0d_timeout", v), 64'd1, 64'd0);
        break;
      end
      en = ($urandom_range(99) >= stall_pct);
      if (poke && !poked && o_count_sload == 3'd3) begin
        i_start = 1'b1;
        en      = 1'b1;
        poked   = 1'b1;
      end
      i_enable = en;
      if (en && o_busy) seq.push_back({o_count_out, 1'b0, o_count_sload});
    end
    i_enable = 1'b1;
    check($sformatf("v%0d_done_pulses", v), n_done, 1);
    check($sformatf("v%0d_idle_state", v), {o_count_out, o_w_addr, o_busy, o_done},
          {4'd0, 10'd0, 1'b0, 1'b0});
    check($sformatf("v%0d_seq_len", v), seq.size(), 20);
    for (int n = 1; n <= 2; n++) begin
      for (int k = 0; k < 10; k++) begin
        exp_e = {4'(n), 1'b0, (k < 5) ? 3'd0 : 3'(k - 4)};
        if ((n - 1) * 10 + k < seq.size())
          check($sformatf("v%0d_seq%0d", v, (n - 1) * 10 + k), seq[(n - 1) * 10 + k], exp_e);
      end
    end
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 1024; i++) w_mem[i] = '0;
    for (int i = 0; i < 4; i++) in_mem[i] = '0;

    vecs[0].in_v = {4{16'h1000}}; vecs[0].w0 = {4{16'h0001}}; vecs[0].w1 = {4{16'h0001}};
    vecs[0].r0 = 32'h0000_4000;   vecs[0].r1 = 32'h0000_4000;
    vecs[1].in_v = {4{16'hFFFE}}; vecs[1].w0 = {4{16'h0003}}; vecs[1].w1 = {4{16'h0003}};
    vecs[1].r0 = 32'hFFFF_FFE8;   vecs[1].r1 = 32'hFFFF_FFE8;
    vecs[2].in_v = {4{16'h7FFF}}; vecs[2].w0 = {4{16'h7FFF}}; vecs[2].w1 = {4{16'h7FFF}};
    vecs[3].in_v = {4{16'h8000}}; vecs[3].w0 = {4{16'h8000}}; vecs[3].w1 = {4{16'h8000}};
    vecs[4].in_v = {16'd4, 16'd3, 16'd2, 16'd1};
    vecs[4].w0   = {16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001};
    vecs[4].w1   = {16'hFFFD, 16'h0000, 16'h0000, 16'h0002};
    vecs[4].r0 = 32'hFFFF_FFFE;   vecs[4].r1 = 32'hFFFF_FFF6;
    vecs[5].in_v = {4{16'h8000}}; vecs[5].w0 = {4{16'h7FFF}}; vecs[5].w1 = {4{16'h0000}};
    vecs[5].r1 = 32'h0000_0000;
`ifdef FC_ACCUM_SAT_EN
    vecs[2].r0 = 32'h7FFF_FFFF; vecs[2].r1 = 32'h7FFF_FFFF;
    vecs[3].r0 = 32'h7FFF_FFFF; vecs[3].r1 = 32'h7FFF_FFFF;
    vecs[5].r0 = 32'h8000_0000;
`else
    vecs[2].r0 = 32'hFFFC_0004; vecs[2].r1 = 32'hFFFC_0004;
    vecs[3].r0 = 32'h0000_0000; vecs[3].r1 = 32'h0000_0000;
    vecs[5].r0 = 32'h0002_0000;
`endif

    reset = 1'b1; i_enable = 1'b0; i_start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_state",
          {o_result, o_in_addr, o_w_addr, o_count_sload, o_count_out, o_busy, o_done}, 64'd0);

    for (int v = 0; v < 6; v++) run_vec(v, 0, 1'b0);

    run_vec(0, 30, 1'b0);
    run_vec(4, 40, 1'b0);
    run_vec(5, 25, 1'b0);
    run_vec(1, 0, 1'b1);

    // Reset in the middle of neuron 2's accumulation.
    load_vec(0);
    @(negedge clock);
    i_enable = 1'b1; i_start = 1'b1;
    @(negedge clock);
    i_start = 1'b0;
    guard = 0;
    while (!(o_count_out == 4'd2 && o_in_addr == 2'd2 && o_busy) && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    check("reach_neuron2_mac", guard < 200, 1'b1);
    reset = 1'b1;
    #1;
    check("reset_mid_mac",
          {o_result, o_in_addr, o_w_addr, o_count_sload, o_count_out, o_busy, o_done}, 64'd0);
    repeat (2) begin
      @(negedge clock);
      check("no_done_in_reset", o_done, 1'b0);
    end
    reset = 1'b0;
    @(negedge clock);
    check("idle_after_reset", {o_busy, o_done, o_count_out}, 6'd0);
    run_vec(0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
